// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - sprite geometry, colours and op encodings shared with the game FSM
package sprite_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BOX_W    = 10;
  localparam int BOX_H    = 25;
  localparam int START_X  = 75;
  localparam int START_Y  = 0;
  localparam int STEP_X   = 2;

  localparam int CX_W = $clog2(BOX_W);
  localparam int CY_W = $clog2(BOX_H);

  localparam logic [2:0] FG_COLOUR   = 3'b010;
  localparam logic [2:0] BG_COLOUR   = 3'b000;
  localparam logic [2:0] OVER_COLOUR = 3'b100;

  localparam logic [1:0] OP_DRAW  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_OVER  = 2'b10;

  // Pending horizontal move, two's complement -1/0/+1
  localparam logic [1:0] PEND_NONE  = 2'b00;
  localparam logic [1:0] PEND_RIGHT = 2'b01;
  localparam logic [1:0] PEND_LEFT  = 2'b11;

  function automatic logic [2:0] op_colour(input logic [1:0] op, input logic odd);
    case (op)
      OP_DRAW: return odd ? ~FG_COLOUR : FG_COLOUR;
      OP_OVER: return OVER_COLOUR;
      default: return BG_COLOUR;
    endcase
  endfunction

endpackage

// File: rtl/sprite_datapath_pixel_sweep_counter.sv
// rtl/sprite_datapath_pixel_sweep_counter.sv - raster cx/cy counter over a W x H box
module pixel_sweep_counter #(
  parameter int W   = 10,
  parameter int H   = 25,
  parameter int CXW = $clog2(W),
  parameter int CYW = $clog2(H)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           en,
  output logic [CXW-1:0] cx,
  output logic [CYW-1:0] cy,
  output logic           last
);

  localparam logic [CXW-1:0] CX_MAX = CXW'(W - 1);
  localparam logic [CYW-1:0] CY_MAX = CYW'(H - 1);

  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en) begin
      if (cx_q == CX_MAX) begin
        cx_d = '0;
        cy_d = (cy_q == CY_MAX) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (cx_q == CX_MAX) && (cy_q == CY_MAX);

endmodule

// File: rtl/sprite_datapath.sv
// rtl/sprite_datapath.sv - sprite position owner and box sweeper feeding the VGA adapter
// Optional SPRITE_CHECKER_EN: draw op uses a checkerboard of FG_COLOUR and its inverse.
module sprite_datapath
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       soft_reset_n,
  input  logic       move_en,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       load_coord,
  input  logic       datapath_en,
  input  logic       plot_in,
  input  logic [1:0] op,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       vga_plot,
  output logic       sweep_done,
  output logic       touch_edge
);

  localparam logic [7:0]        MAX_X = 8'(SCREEN_W - BOX_W);
  localparam logic [6:0]        MAX_Y = 7'(SCREEN_H - BOX_H);
  localparam logic signed [8:0] STEP9 = 9'(STEP_X);

  logic [7:0] pos_x_q, pos_x_d;
  logic [6:0] pos_y_q, pos_y_d;
  logic [1:0] pend_dx_q, pend_dx_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;

  logic [CX_W-1:0]  cx;
  logic [CY_W-1:0]  cy;
  logic             last;
  logic             cnt_clear, cnt_en, chk_odd;
  logic signed [8:0] nx;

  assign cnt_clear = ~soft_reset_n | load_coord;
  assign cnt_en    = soft_reset_n & ~load_coord & datapath_en;

  pixel_sweep_counter #(.W(BOX_W), .H(BOX_H)) u_sweep (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (cnt_clear),
    .en    (cnt_en),
    .cx    (cx),
    .cy    (cy),
    .last  (last)
  );

`ifdef SPRITE_CHECKER_EN
  assign chk_odd = cx[0] ^ cy[0];
`else
  assign chk_odd = 1'b0;
`endif

  // Signed so a left step from x<STEP_X goes negative and clamps to 0
  always_comb begin
    nx = $signed({1'b0, pos_x_q});
    if (pend_dx_q == PEND_RIGHT)     nx = nx + STEP9;
    else if (pend_dx_q == PEND_LEFT) nx = nx - STEP9;
  end

  always_comb begin
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    pend_dx_d = pend_dx_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    done_d    = 1'b0;
    if (!soft_reset_n) begin
      pos_x_d   = 8'(START_X);
      pos_y_d   = 7'(START_Y);
      pend_dx_d = PEND_NONE;
      x_d       = '0;
      y_d       = '0;
      colour_d  = '0;
    end else if (load_coord) begin
      if (nx < 9'sd0)                      pos_x_d = '0;
      else if (nx > $signed({1'b0, MAX_X})) pos_x_d = MAX_X;
      else                                 pos_x_d = nx[7:0];
      pos_y_d   = (pos_y_q == MAX_Y) ? pos_y_q : pos_y_q + 7'd1;
      pend_dx_d = PEND_NONE;
    end else begin
      if (move_en) begin
        if (key_left && !key_right)      pend_dx_d = PEND_LEFT;
        else if (key_right && !key_left) pend_dx_d = PEND_RIGHT;
      end
      if (datapath_en) begin
        x_d      = pos_x_q + 8'(cx);
        y_d      = pos_y_q + 7'(cy);
        colour_d = op_colour(op, chk_odd);
        plot_d   = plot_in;
        done_d   = last;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x_q   <= 8'(START_X);
      pos_y_q   <= 7'(START_Y);
      pend_dx_q <= PEND_NONE;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      pend_dx_q <= pend_dx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      done_q    <= done_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign vga_plot   = plot_q;
  assign sweep_done = done_q;
  assign touch_edge = (pos_y_q == MAX_Y);

endmodule

// File: doc/sprite_datapath.md
Name: sprite_datapath

Overview:
- Datapath stage directly downstream of the game control FSM.
- Consumes its move_en / load_coord / datapath_en / plot / op / reset_n_out strobes and owns the sprite position.
- Sweeps a BOX_W x BOX_H pixel rectangle and drives x/y/colour/plot to the VGA adapter.
- Reports end-of-sweep and floor contact back to the FSM.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- BOX_W, 10, sprite width.
- BOX_H, 25, sprite height (BOX_W*BOX_H = 250 pixels per sweep).
- START_X, 75, x position after reset or soft clear.
- START_Y, 0, y position after reset or soft clear.
- STEP_X, 2, horizontal pixels moved per load_coord.
- FG_COLOUR, 3'b010, draw colour.
- BG_COLOUR, 3'b000, erase colour.
- OVER_COLOUR, 3'b100, game-over colour.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- soft_reset_n  in  1  synchronous active-low clear, driven by FSM reset_n_out.
- move_en  in  1  key sampling window.
- key_left  in  1  move left; synchronised, active-high.
- key_right  in  1  move right; synchronised, active-high.
- load_coord  in  1  single-cycle position-update strobe.
- datapath_en  in  1  advance the pixel sweep.
- plot_in  in  1  FSM plot request.
- op  in  2  00 draw, 01 erase, 10 game-over, 11 erase.
- x  out  8  pixel x.
- y  out  7  pixel y.
- colour  out  3  pixel colour.
- vga_plot  out  1  write strobe to the VGA adapter.
- sweep_done  out  1  one-cycle pulse on the last pixel.
- touch_edge  out  1  level; high while the sprite rests on the floor.

Behaviour:
- Reset (reset_n low, async):
  - pos_x=START_X, pos_y=START_Y, pend_dx=0, cx=cy=0.
  - x=0, y=0, colour=0, vga_plot=0, sweep_done=0, touch_edge=0.
- soft_reset_n low at a clock edge: same values as reset, applied synchronously. It overrides every other input that cycle.
- Key capture, while move_en=1, each cycle:
  - key_left only: pend_dx=-1.
  - key_right only: pend_dx=+1.
  - both keys or neither: pend_dx holds.
  - move_en=0: pend_dx holds.
- load_coord=1, single cycle:
  - pos_x' = clamp(pos_x + pend_dx*STEP_X, 0, SCREEN_W-BOX_W). Compute in 9-bit signed so underflow clamps to 0.
  - pos_y' = min(pos_y+1, SCREEN_H-BOX_H).
  - pend_dx cleared to 0.
  - cx=cy=0.
  - vga_plot=0 that cycle.
- touch_edge = (pos_y == SCREEN_H-BOX_H). Combinational from the register.
- Sweep, datapath_en=1 and load_coord=0:
  - Registered outputs, 1-cycle latency:
    - x <= pos_x+cx, y <= pos_y+cy.
    - colour <= FG_COLOUR for op 00, BG_COLOUR for op 01 or 11, OVER_COLOUR for op 10.
    - vga_plot <= plot_in.
  - Then cx++. At cx=BOX_W-1, cx wraps to 0 and cy++.
  - At cx=BOX_W-1 and cy=BOX_H-1, both wrap to 0 and sweep_done <= 1 for one cycle. sweep_done coincides with the last pixel's outputs.
- datapath_en=0: counters hold; vga_plot <= 0; x/y/colour hold. A resumed sweep continues exactly where it stopped.
- load_coord and datapath_en high together: load_coord wins, no pixel is emitted, counters clear.
- Erase is swept before load_coord, so it always covers the old position. Position never changes during a sweep.
- One full sweep takes exactly BOX_W*BOX_H enabled cycles.

Optional Feature:
- Macro: SPRITE_CHECKER_EN.
- Defined: op 00 colour is FG_COLOUR when cx[0]^cy[0]==0, else ~FG_COLOUR (checker pattern).
- Undefined: op 00 draws solid FG_COLOUR.
- Erase and game-over colours are the same in both builds.

Decomposition:
- Shared package sprite_pkg holds:
  - SCREEN_W, SCREEN_H, BOX_W, BOX_H defaults.
  - Colour constants.
  - Op encoding localparams OP_DRAW=2'b00, OP_ERASE=2'b01, OP_OVER=2'b10, shared with the FSM.
- Sub-module pixel_sweep_counter: holds cx/cy, with inputs en and clear and outputs cx, cy, last. Used once here; reusable for a full-screen clear.

Test Plan:
- Reset mid-sweep: assert reset_n low at cycle 37 of a sweep -> all outputs 0 immediately (async), pos returns to (75,0), next sweep starts at (75,0).
- Full draw sweep: load_coord then 250 cycles of datapath_en with op=00 and plot_in=1 ->
  - first pixel (75,1), colour 010;
  - last pixel (84,25);
  - exactly 250 vga_plot pulses;
  - sweep_done high only with pixel (84,25).
- Stall: drop datapath_en for 5 cycles after pixel 12 -> vga_plot=0 for those cycles; pixel 13 is (77,2) on resume; still 250 pixels total.
- Keys:
  - key_left held in move_en at pos_x=1, then load_coord -> pos_x=0 (clamped).
  - key_right at pos_x=149 -> pos_x=150.
  - both keys pressed -> pos_x unchanged.
- Floor: issue 95 load_coords from reset -> pos_y=95 and touch_edge=1; a 96th load_coord keeps pos_y=95.
- Priority: load_coord with datapath_en high mid-sweep -> no vga_plot that cycle, counters return to 0. soft_reset_n low together with load_coord -> pos=(75,0).
